serial_alu_seq: RTL and testbench

- Bit-serial sequencer on the driving side of the 1-bit ALU slice interface (funct-code select plus AND/OR/FA/SLT result mux).
- Accepts a WIDTH-bit operation and presents operand bits, carry and funct select to one external slice, LSB first.
- Collects the slice output into a result register and reports done, zero and error flags.
- Replaces WIDTH parallel slices where area matters more than latency.

---
 rtl/serial_alu_seq.sv | 187 ++++++++++++++++++
 tb/tb_serial_alu_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: drives one external 1-bit ALU slice LSB first and collects the result.
// Optional macro SERIAL_ALU_OVF_EN enables the signed-overflow flag; otherwise overflow is tied to 0.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       funct,
  output logic [5:0]       slice_sel,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_less,
  input  logic             slice_out,
  input  logic             slice_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic             overflow
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  localparam logic [5:0] F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_AND = 6'd36;
  localparam logic [5:0] F_OR  = 6'd37;
  localparam logic [5:0] F_SLT = 6'd42;

  typedef enum logic [1:0] {IDLE, RUN, SLTFIX, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_next;
  logic [5:0]       funct_reg;
  logic [IW-1:0]    idx_reg;
  logic             carry_reg;
  logic             msb_sum_reg;
  logic             cin_msb_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             zero_reg;
  logic             err_reg;
  logic             inv;
  logic             last_bit;
  logic             start_legal;

  assign start_legal = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                       (funct == F_OR)  || (funct == F_SLT);
  assign inv      = (funct_reg == F_SUB) || (funct_reg == F_SLT);
  assign last_bit = (idx_reg == LAST_IDX);

  // Slice drive is decoded purely from registered state, so it is stable for the whole cycle.
  always_comb begin
    slice_sel  = 6'd0;
    slice_a    = 1'b0;
    slice_b    = 1'b0;
    slice_cin  = 1'b0;
    slice_less = 1'b0;
    case (state_reg)
      RUN: begin
        slice_sel = (funct_reg == F_SLT) ? F_SUB : funct_reg;
        slice_a   = a_reg[idx_reg];
        slice_b   = b_reg[idx_reg] ^ inv;
        slice_cin = carry_reg;
      end
      SLTFIX: begin
        // carry_reg now holds the MSB carry-out; less is the overflow-corrected sign.
        slice_sel  = F_SLT;
        slice_a    = a_reg[0];
        slice_b    = ~b_reg[0];
        slice_less = msb_sum_reg ^ (cin_msb_reg ^ carry_reg);
      end
      default: ;
    endcase
  end

  always_comb begin
    result_next          = result_reg;
    result_next[idx_reg] = slice_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      funct_reg   <= 6'd0;
      idx_reg     <= '0;
      carry_reg   <= 1'b0;
      msb_sum_reg <= 1'b0;
      cin_msb_reg <= 1'b0;
      result_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      zero_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (start_legal) begin
              a_reg     <= a;
              b_reg     <= b;
              funct_reg <= funct;
              idx_reg   <= '0;
              carry_reg <= (funct == F_SUB) || (funct == F_SLT);
              err_reg   <= 1'b0;
              busy_reg  <= 1'b1;
              state_reg <= RUN;
            end else begin
              result_reg <= '0;
              zero_reg   <= 1'b1;
              err_reg    <= 1'b1;
              done_reg   <= 1'b1;
              state_reg  <= DONE;
            end
          end
        end
        RUN: begin
          result_reg <= result_next;
          carry_reg  <= slice_cout;
          idx_reg    <= idx_reg + 1'b1;
          if (last_bit) begin
            msb_sum_reg <= slice_out;
            cin_msb_reg <= carry_reg;
            if (funct_reg == F_SLT) begin
              state_reg <= SLTFIX;
            end else begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              zero_reg  <= (result_next == '0);
              state_reg <= DONE;
            end
          end
        end
        SLTFIX: begin
          result_reg <= {{(WIDTH-1){1'b0}}, slice_out};
          zero_reg   <= ~slice_out;
          busy_reg   <= 1'b0;
          done_reg   <= 1'b1;
          state_reg  <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  logic overflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (state_reg == IDLE && start && !start_legal) begin
      overflow_reg <= 1'b0;
    end else if (state_reg == RUN && last_bit && funct_reg != F_SLT) begin
      overflow_reg <= ((funct_reg == F_ADD) || (funct_reg == F_SUB)) & (carry_reg ^ slice_cout);
    end else if (state_reg == SLTFIX) begin
      overflow_reg <= cin_msb_reg ^ carry_reg;
    end
  end

  assign overflow = overflow_reg;
`else
  assign overflow = 1'b0;
`endif

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign zero   = zero_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq (WIDTH=8) with a behavioural 1-bit ALU slice.
module tb_serial_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [5:0] funct = 6'd0;
  logic [5:0] slice_sel;
  logic       slice_a, slice_b, slice_cin, slice_less;
  logic       slice_out, slice_cout;
  logic       busy, done, zero, err, overflow;
  logic [7:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural slice: AND / OR / full-adder sum / SLT less pass-through.
  always_comb begin
    slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
    case (slice_sel)
      6'd36:        slice_out = slice_a & slice_b;
      6'd37:        slice_out = slice_a | slice_b;
      6'd32, 6'd34: slice_out = slice_a ^ slice_b ^ slice_cin;
      6'd42:        slice_out = slice_less;
      default:      slice_out = 1'b0;
    endcase
  end

  serial_alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .funct(funct),
    .slice_sel(slice_sel), .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_less(slice_less), .slice_out(slice_out), .slice_cout(slice_cout),
    .busy(busy), .done(done), .result(result), .zero(zero), .err(err), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after a clock edge; returns edges from the start edge to done high.
  task automatic run_op(input logic [5:0] f, input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output logic busy_seen);
    funct = f; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_seen = busy;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_seen = 1'b1;
    end
  endtask

  typedef struct {
    logic [5:0] funct;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       zero;
    logic       err;
    logic       ovf;
    logic       busy_seen;
    int         lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int   lat;
    int   dones;
    logic bs;
    logic exp_ovf;

    vecs[0] = '{6'd32, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 9};
    vecs[1] = '{6'd34, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 9};
    vecs[2] = '{6'd34, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 9};
    vecs[3] = '{6'd42, 8'hFD, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 10};
    vecs[4] = '{6'd42, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 10};
    vecs[5] = '{6'd36, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1, 9};
    vecs[6] = '{6'd37, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b1, 9};
    vecs[7] = '{6'd33, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {28'd0, busy, done, zero, err}, 32'd0);
    check("reset_result", {24'd0, result}, 32'd0);
    check("reset_ovf", {31'd0, overflow}, 32'd0);
    check("reset_slice", {21'd0, slice_sel, slice_a, slice_b, slice_cin, slice_less}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].funct, vecs[i].a, vecs[i].b, lat, bs);
`ifdef SERIAL_ALU_OVF_EN
      exp_ovf = vecs[i].ovf;
`else
      exp_ovf = 1'b0;
`endif
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_result", i), {24'd0, result}, {24'd0, vecs[i].res});
      check($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].zero});
      check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      check($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, exp_ovf});
      check($sformatf("v%0d_busy_seen", i), {31'd0, bs}, {31'd0, vecs[i].busy_seen});
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      $display("vec %0d funct=%0d a=%02h b=%02h -> result=%02h zero=%0b err=%0b ovf=%0b lat=%0d",
               i, vecs[i].funct, vecs[i].a, vecs[i].b, result, zero, err, overflow, lat);
    end

    // start pulsed while RUN is at bit 3 must be ignored.
    funct = 6'd32; a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    funct = 6'd36; a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat++;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    check("ignore_start_latency", lat, 9);
    check("ignore_start_result", {24'd0, result}, 32'h46);
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("ignore_start_no_queue", dones, 0);
    $display("ignored-start op: result=%02h lat=%0d", result, lat);

    // Reset at bit 4 aborts the operation with no done pulse.
    funct = 6'd34; a = 8'h10; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", {24'd0, result}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    dones = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    $display("aborted op: busy=%0b result=%02h done_pulses=%0d", busy, result, dones);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
